// File: rtl/commit_stage_pkg.sv
// commit_stage_pkg: shared destination encodings, register selectors, FSM states and the captured step.
package commit_stage_pkg;
  localparam logic [1:0] OPND_DEST_NONE     = 2'd0;
  localparam logic [1:0] OPND_DEST_REG_1HOT = 2'd1;
  localparam logic [1:0] OPND_DEST_MEM_1HOT = 2'd2;
  localparam logic [2:0] REG_EAX = 3'd0;
  localparam logic [2:0] REG_ECX = 3'd1;
  localparam logic [2:0] REG_EDX = 3'd2;
  localparam logic [2:0] REG_EBX = 3'd3;
  localparam logic [2:0] REG_ESP = 3'd4;
  localparam logic [2:0] REG_EBP = 3'd5;
  localparam logic [2:0] REG_ESI = 3'd6;
  localparam logic [2:0] REG_EDI = 3'd7;
  typedef enum logic [1:0] {IDLE, COMMIT, FAULT} state_t;
  typedef struct packed {
    logic [1:0]  kind0;
    logic [31:0] sel0;
    logic [31:0] val0;
    logic [1:0]  kind1;
    logic [31:0] sel1;
    logic [31:0] val1;
    logic        reg_1byte;
    logic        op16;
    logic        h1w;
    logic [31:0] h1a;
    logic [31:0] h1d;
    logic        h2w;
    logic [31:0] h2a;
    logic [31:0] h2d;
    logic [31:0] next_eip;
  } step_t;
  // Byte selectors 4-7 name the high byte of regs 0-3, not regs 4-7.
  function automatic logic [2:0] reg_index(input logic [2:0] sel, input logic byte1);
    return byte1 ? {1'b0, sel[1:0]} : sel;
  endfunction
  function automatic logic dest_err(input logic [1:0] kind, input logic [31:0] sel, input logic [31:0] val, input step_t s);
    return kind == 2'b11 || (kind == OPND_DEST_MEM_1HOT &&
      !((s.h1w && s.h1a == sel && s.h1d == val) || (s.h2w && s.h2a == sel && s.h2d == val)));
  endfunction
endpackage

// File: rtl/commit_stage_reg_merge.sv
// reg_merge: merges a new value into an old register value at 8/16/32-bit width.
module reg_merge (
  input  logic [31:0] old_val,
  input  logic [31:0] new_val,
  input  logic        sel_hi,
  input  logic        reg_1byte,
  input  logic        op16,
  output logic [31:0] merged
);
  assign merged = reg_1byte ? (sel_hi ? {old_val[31:16], new_val[7:0], old_val[7:0]} : {old_val[31:8], new_val[7:0]})
                : op16 ? {old_val[31:16], new_val[15:0]} : new_val;
endmodule

// File: rtl/commit_stage.sv
// commit_stage: captures a retired step, then commits its register/eip writes or faults on a bad dest.
module commit_stage
  import commit_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  dest0_kind,
  input  logic [1:0]  dest1_kind,
  input  logic [31:0] dest0_sel,
  input  logic [31:0] dest1_sel,
  input  logic [31:0] dest0_val,
  input  logic [31:0] dest1_val,
  input  logic        reg_1byte,
  input  logic        prefix_operand_16bit,
  input  logic        hint1_is_write,
  input  logic        hint2_is_write,
  input  logic [31:0] hint1_address,
  input  logic [31:0] hint1_data,
  input  logic [31:0] hint2_address,
  input  logic [31:0] hint2_data,
  input  logic [31:0] next_eip,
  output logic [31:0] eax,
  output logic [31:0] ecx,
  output logic [31:0] edx,
  output logic [31:0] ebx,
  output logic [31:0] esp,
  output logic [31:0] ebp,
  output logic [31:0] esi,
  output logic [31:0] edi,
  output logic [31:0] eip,
  output logic [31:0] step_count,
  output logic        commit_pulse,
  output logic        fault
);
  state_t      state, state_n;
  step_t       cap;
  logic [31:0] regs [8];
  logic [31:0] regs_a [8];
  logic [31:0] regs_b [8];
  logic [31:0] eip_q, step_q, m0, m1;
  logic [2:0]  i0, i1;
  logic        err, commit_ok;
  assign i0 = reg_index(cap.sel0[2:0], cap.reg_1byte);
  assign i1 = reg_index(cap.sel1[2:0], cap.reg_1byte);
  reg_merge u_merge0 (.old_val(regs[i0]), .new_val(cap.val0), .sel_hi(cap.sel0[2]),
                      .reg_1byte(cap.reg_1byte), .op16(cap.op16), .merged(m0));
  reg_merge u_merge1 (.old_val(regs_a[i1]), .new_val(cap.val1), .sel_hi(cap.sel1[2]),
                      .reg_1byte(cap.reg_1byte), .op16(cap.op16), .merged(m1));
  // dest1 merges on top of dest0's result so it wins on overlapping bits.
  always_comb begin
    regs_a = regs;
    if (cap.kind0 == OPND_DEST_REG_1HOT) regs_a[i0] = m0;
  end
  always_comb begin
    regs_b = regs_a;
    if (cap.kind1 == OPND_DEST_REG_1HOT) regs_b[i1] = m1;
  end
  always_comb begin
    err       = dest_err(cap.kind0, cap.sel0, cap.val0, cap) | dest_err(cap.kind1, cap.sel1, cap.val1, cap);
    commit_ok = state == COMMIT && !err;
    state_n   = state == IDLE ? (in_valid ? COMMIT : IDLE) : state == COMMIT ? (err ? FAULT : IDLE) : FAULT;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      regs   <= '{default: '0};
      eip_q  <= '0;
      step_q <= '0;
    end else begin
      state <= state_n;
      if (commit_ok) begin
        regs   <= regs_b;
        eip_q  <= cap.next_eip;
        step_q <= step_q + 32'd1;
      end
    end
  end
  always_ff @(posedge clk)
    if (state == IDLE && in_valid)
      cap <= '{kind0: dest0_kind, sel0: dest0_sel, val0: dest0_val, kind1: dest1_kind, sel1: dest1_sel,
               val1: dest1_val, reg_1byte: reg_1byte, op16: prefix_operand_16bit, h1w: hint1_is_write,
               h1a: hint1_address, h1d: hint1_data, h2w: hint2_is_write, h2a: hint2_address,
               h2d: hint2_data, next_eip: next_eip};
  assign in_ready     = state == IDLE;
  assign fault        = state == FAULT;
  assign commit_pulse = commit_ok;
  assign step_count   = step_q;
  assign eip          = eip_q;
  assign {eax, ecx, edx, ebx, esp, ebp, esi, edi} = {regs[0], regs[1], regs[2], regs[3], regs[4], regs[5], regs[6], regs[7]};
endmodule

// File: tb/tb_commit_stage.sv
// tb_commit_stage: directed vectors with hand-computed expectations for commit_stage.
module tb_commit_stage;
  import commit_stage_pkg::*;
  logic        clk = 0, rst = 1, in_valid = 0, in_ready;
  logic [1:0]  dest0_kind = 0, dest1_kind = 0;
  logic [31:0] dest0_sel = 0, dest1_sel = 0, dest0_val = 0, dest1_val = 0;
  logic        reg_1byte = 0, prefix_operand_16bit = 0, hint1_is_write = 0, hint2_is_write = 0;
  logic [31:0] hint1_address = 0, hint1_data = 0, hint2_address = 0, hint2_data = 0, next_eip = 0;
  logic [31:0] eax, ecx, edx, ebx, esp, ebp, esi, edi, eip, step_count;
  logic        commit_pulse, fault;
  int          n_checks = 0, n_err = 0;
  logic        pulse;
  logic [31:0] mid_eax;
  int          pulses;

  commit_stage dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .dest0_kind(dest0_kind), .dest1_kind(dest1_kind), .dest0_sel(dest0_sel), .dest1_sel(dest1_sel),
    .dest0_val(dest0_val), .dest1_val(dest1_val), .reg_1byte(reg_1byte),
    .prefix_operand_16bit(prefix_operand_16bit), .hint1_is_write(hint1_is_write),
    .hint2_is_write(hint2_is_write), .hint1_address(hint1_address), .hint1_data(hint1_data),
    .hint2_address(hint2_address), .hint2_data(hint2_data), .next_eip(next_eip),
    .eax(eax), .ecx(ecx), .edx(edx), .ebx(ebx), .esp(esp), .ebp(ebp), .esi(esi), .edi(edi),
    .eip(eip), .step_count(step_count), .commit_pulse(commit_pulse), .fault(fault));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1;
    @(negedge clk) rst = 0;
  endtask

  // Offers one step at a negedge, returns commit_pulse and eax seen in the COMMIT cycle.
  task automatic send(input logic [1:0] k0, input logic [31:0] s0, input logic [31:0] v0,
                      input logic [1:0] k1, input logic [31:0] s1, input logic [31:0] v1,
                      input logic b1, input logic w16, input logic [31:0] ne,
                      output logic p, output logic [31:0] mid);
    int n = 0;
    while (!in_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("ready_timeout", {31'd0, in_ready}, 32'd1);
    {dest0_kind, dest0_sel, dest0_val, dest1_kind, dest1_sel, dest1_val} = {k0, s0, v0, k1, s1, v1};
    {reg_1byte, prefix_operand_16bit, next_eip} = {b1, w16, ne};
    in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    p = commit_pulse;
    mid = eax;
    @(negedge clk);
  endtask

  initial begin
    do_reset();
    check("rst_eax", eax, 0);
    check("rst_step", step_count, 0);
    check("rst_eip", eip, 0);
    check("rst_ready", {31'd0, in_ready}, 1);
    check("rst_fault", {31'd0, fault}, 0);

    send(OPND_DEST_REG_1HOT, REG_EAX, 32'h12345678, OPND_DEST_NONE, 0, 0, 0, 0, 32'h100, pulse, mid_eax);
    check("w32_mid_eax", mid_eax, 0);
    check("w32_pulse", {31'd0, pulse}, 1);
    check("w32_eax", eax, 32'h12345678);
    check("w32_step", step_count, 1);
    check("w32_eip", eip, 32'h100);
    check("w32_pulse_off", {31'd0, commit_pulse}, 0);

    send(OPND_DEST_REG_1HOT, REG_EAX, 32'h11223344, OPND_DEST_NONE, 0, 0, 0, 0, 32'h104, pulse, mid_eax);
    send(OPND_DEST_REG_1HOT, 4, 32'hAB, OPND_DEST_NONE, 0, 0, 1, 0, 32'h108, pulse, mid_eax);
    check("ah_write", eax, 32'h1122AB44);
    send(OPND_DEST_REG_1HOT, REG_EAX, 32'hBEEF, OPND_DEST_NONE, 0, 0, 0, 1, 32'h10C, pulse, mid_eax);
    check("ax_write", eax, 32'h1122BEEF);

    send(OPND_DEST_REG_1HOT, REG_ECX, 1, OPND_DEST_REG_1HOT, REG_ECX, 2, 0, 0, 32'h110, pulse, mid_eax);
    check("overlap_ecx", ecx, 2);
    send(OPND_DEST_REG_1HOT, 0, 32'h11, OPND_DEST_REG_1HOT, 4, 32'h22, 1, 0, 32'h114, pulse, mid_eax);
    check("al_ah_eax", eax, 32'h11222211);
    send(OPND_DEST_REG_1HOT, REG_EBX, 32'hCAFEF00D, OPND_DEST_REG_1HOT, REG_EDI, 32'h77, 0, 0, 32'h118, pulse, mid_eax);
    send(OPND_DEST_REG_1HOT, 7, 32'h5A, OPND_DEST_NONE, 0, 0, 1, 0, 32'h11C, pulse, mid_eax);
    check("bh_write", ebx, 32'hCAFE5A0D);
    check("edi_write", edi, 32'h77);
    check("step_count_8", step_count, 8);

    send(OPND_DEST_NONE, 0, 0, OPND_DEST_NONE, 0, 0, 0, 0, 32'h200, pulse, mid_eax);
    check("none_eip", eip, 32'h200);
    check("none_step", step_count, 9);
    check("none_eax", eax, 32'h11222211);

    {hint2_is_write, hint2_address, hint2_data} = {1'b1, 32'h1000, 32'd5};
    send(OPND_DEST_MEM_1HOT, 32'h1000, 5, OPND_DEST_NONE, 0, 0, 0, 0, 32'h204, pulse, mid_eax);
    check("mem_ok_pulse", {31'd0, pulse}, 1);
    check("mem_ok_fault", {31'd0, fault}, 0);
    check("mem_ok_step", step_count, 10);
    hint2_data = 6;
    send(OPND_DEST_MEM_1HOT, 32'h1000, 5, OPND_DEST_REG_1HOT, REG_EAX, 32'h99, 0, 0, 32'h208, pulse, mid_eax);
    check("mem_bad_pulse", {31'd0, pulse}, 0);
    check("mem_bad_fault", {31'd0, fault}, 1);
    check("mem_bad_ready", {31'd0, in_ready}, 0);
    check("mem_bad_eax", eax, 32'h11222211);
    check("mem_bad_step", step_count, 10);
    check("mem_bad_eip", eip, 32'h204);
    repeat (3) @(negedge clk);
    check("fault_sticky", {31'd0, fault}, 1);
    hint2_is_write = 0;
    do_reset();
    check("fault_rst_fault", {31'd0, fault}, 0);
    check("fault_rst_ready", {31'd0, in_ready}, 1);
    check("fault_rst_ebx", ebx, 0);

    send(2'b11, 0, 0, OPND_DEST_NONE, 0, 0, 0, 0, 32'h300, pulse, mid_eax);
    check("kind3_fault", {31'd0, fault}, 1);
    check("kind3_step", step_count, 0);
    do_reset();

    dut.step_q <= 32'hFFFF_FFFE;
    @(negedge clk);
    send(OPND_DEST_NONE, 0, 0, OPND_DEST_NONE, 0, 0, 0, 0, 32'h400, pulse, mid_eax);
    check("step_max", step_count, 32'hFFFF_FFFF);
    send(OPND_DEST_NONE, 0, 0, OPND_DEST_NONE, 0, 0, 0, 0, 32'h404, pulse, mid_eax);
    check("step_wrap", step_count, 0);

    send(OPND_DEST_REG_1HOT, REG_ESI, 32'h55, OPND_DEST_NONE, 0, 0, 0, 0, 32'h408, pulse, mid_eax);
    check("esi_pre", esi, 32'h55);
    {dest0_kind, dest0_sel, dest0_val, next_eip} = {OPND_DEST_REG_1HOT, 32'd0, 32'hDEAD, 32'h500};
    in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("rst_commit_eax", eax, 0);
    check("rst_commit_esi", esi, 0);
    check("rst_commit_eip", eip, 0);
    check("rst_commit_step", step_count, 0);
    check("rst_commit_pulse", {31'd0, commit_pulse}, 0);
    check("rst_commit_ready", {31'd0, in_ready}, 1);
    @(negedge clk);
    check("rst_commit_lost", eax, 0);

    {dest0_kind, dest0_sel, dest0_val, dest1_kind} = {OPND_DEST_REG_1HOT, 32'd2, 32'h0, OPND_DEST_NONE};
    pulses = 0;
    in_valid = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      pulses += int'(commit_pulse);
      dest0_val = dest0_val + 1;
    end
    in_valid = 0;
    @(negedge clk);
    check("stream_pulses", pulses, 10);
    check("stream_step", step_count, 10);
    check("stream_edx", edx, 32'd18);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
